// File: rtl/signed_addsub_scheduler.sv
// Two-requester signed add/subtract unit with round-robin grant and a one-op-in-flight IDLE/EXEC/DONE sequence.
// Optional macro ADDSUB_SAT_EN saturates res_signed on overflow; otherwise the result wraps.
module signed_addsub_scheduler #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid_0,
  input  logic         req_valid_1,
  output logic         req_ready_0,
  output logic         req_ready_1,
  input  logic [N-1:0] a_0,
  input  logic [N-1:0] b_0,
  input  logic [N-1:0] a_1,
  input  logic [N-1:0] b_1,
  input  logic [1:0]   sign_0,
  input  logic [1:0]   sign_1,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_signed,
  output logic         res_id,
  output logic         res_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [N-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]     op_sign_q, op_sign_d;
  logic           op_id_q, op_id_d;
  logic [N-1:0]   res_q, res_d;
  logic           id_q, id_d;
  logic           ovf_q, ovf_d;

  logic           gnt_0, gnt_1;
  logic [N+1:0]   ext_a, ext_b, term_a, term_b, exact;
  logic           exact_ovf;
  logic [N-1:0]   exact_res;

  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req_valid_0 && req_valid_1) begin
        gnt_0 = last_q;
        gnt_1 = !last_q;
      end else begin
        gnt_0 = req_valid_0;
        gnt_1 = req_valid_1;
      end
    end
  end

  // Exact value needs two guard bits: -A-B with both at the negative limit reaches 2^N.
  always_comb begin
    ext_a     = {{2{op_a_q[N-1]}}, op_a_q};
    ext_b     = {{2{op_b_q[N-1]}}, op_b_q};
    term_a    = op_sign_q[1] ? (~ext_a + 1'b1) : ext_a;
    term_b    = op_sign_q[0] ? (~ext_b + 1'b1) : ext_b;
    exact     = term_a + term_b;
    exact_ovf = !((exact[N+1:N-1] == 3'b000) || (exact[N+1:N-1] == 3'b111));
`ifdef ADDSUB_SAT_EN
    if (exact_ovf)
      exact_res = exact[N+1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else
      exact_res = exact[N-1:0];
`else
    exact_res = exact[N-1:0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_sign_d = op_sign_q;
    op_id_d   = op_id_q;
    res_d     = res_q;
    id_d      = id_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_0) begin
          op_a_d = a_0; op_b_d = b_0; op_sign_d = sign_0; op_id_d = 1'b0;
          state_d = EXEC;
        end else if (gnt_1) begin
          op_a_d = a_1; op_b_d = b_1; op_sign_d = sign_1; op_id_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = exact_res;
        ovf_d   = exact_ovf;
        id_d    = op_id_q;
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_sign_q <= '0;
      op_id_q   <= 1'b0;
      res_q     <= '0;
      id_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_sign_q <= op_sign_d;
      op_id_q   <= op_id_d;
      res_q     <= res_d;
      id_q      <= id_d;
      ovf_q     <= ovf_d;
    end
  end

  assign req_ready_0 = gnt_0;
  assign req_ready_1 = gnt_1;
  assign res_valid   = (state_q == DONE);
  assign res_signed  = res_q;
  assign res_id      = id_q;
  assign res_ovf     = ovf_q;

endmodule
